// File: rtl/conv_bank_rotator_pkg.sv
// Shared definitions for the convolution column-bank rotator.
// Holds the default widths, the bank and window counts, the bank-index type
// and a modulo-4 bank-index helper.
package conv_bank_rotator_pkg;

    localparam int unsigned NB_ADDRESS_DEF = 10;
    localparam int unsigned NB_DATA_DEF    = 8;
    localparam int unsigned N_BANKS        = 4;
    localparam int unsigned N_WIN          = 3;
    localparam int unsigned NB_BANK_IDX    = 2;

    typedef logic [NB_BANK_IDX-1:0] bank_idx_t;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_RUN  = 1'b1
    } phase_e;

    // Bank index offset by k, wrapping modulo the bank count.
    function automatic bank_idx_t bank_add(input bank_idx_t b, input int unsigned k);
        return bank_idx_t'(b + bank_idx_t'(k));
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// One column bank: 2^NB_ADDRESS x NB_DATA, single write port, synchronous read.
// Ports:
//   i_CLK    clock
//   i_we     write enable; i_wrData is written at i_wrAdd
//   i_re     read enable; mem[i_rdAdd] appears on o_rdData after the edge
//   o_rdData registered read data (holds while i_re is low)
module conv_bank_ram #(
    parameter int unsigned NB_ADDRESS = 10,
    parameter int unsigned NB_DATA    = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_we,
    input  logic [NB_ADDRESS-1:0] i_wrAdd,
    input  logic [NB_DATA-1:0]    i_wrData,
    input  logic                  i_re,
    input  logic [NB_ADDRESS-1:0] i_rdAdd,
    output logic [NB_DATA-1:0]    o_rdData
);

    localparam int unsigned DEPTH = 1 << NB_ADDRESS;

    logic [NB_DATA-1:0] r_mem [DEPTH];
    logic [NB_DATA-1:0] r_rdData;

    // Storage is not reset; contents survive a reset and are not guaranteed.
    always_ff @(posedge i_CLK) begin
        if (i_we) begin
            r_mem[i_wrAdd] <= i_wrData;
        end
        if (i_re) begin
            r_rdData <= r_mem[i_rdAdd];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/conv_bank_rotator.sv
// Four-bank column buffer for the 2D convolution datapath.
// One bank is loaded from the host while the other three are read in parallel
// as a 3-column window. Bank roles rotate on every i_changeBlock strobe.
// Ports:
//   i_CLK, i_reset      clock, asynchronous active-low reset
//   i_data, i_valid     host pixel and write strobe (into the load bank)
//   i_writeAdd          load-bank address
//   i_readAdd, i_rdEn   window address and read request
//   i_changeBlock       block-complete strobe, rotates bank roles
//   o_pix               window column, oldest bank in the low slice
//   o_pixValid          o_pix holds data for the request two cycles earlier
//   o_windowReady       three banks filled
//   o_loadBank          index of the bank currently being loaded
// Optional feature, macro CONV_BANK_READBACK_EN:
//   i_rbEn, o_rbData    read the load bank at i_writeAdd, data one cycle later
module conv_bank_rotator
    import conv_bank_rotator_pkg::*;
#(
    parameter int unsigned NB_ADDRESS = NB_ADDRESS_DEF,
    parameter int unsigned NB_DATA    = NB_DATA_DEF
) (
    input  logic                     i_CLK,
    input  logic                     i_reset,
    input  logic [NB_DATA-1:0]       i_data,
    input  logic                     i_valid,
    input  logic [NB_ADDRESS-1:0]    i_writeAdd,
    input  logic [NB_ADDRESS-1:0]    i_readAdd,
    input  logic                     i_rdEn,
    input  logic                     i_changeBlock,
    output logic [N_WIN*NB_DATA-1:0] o_pix,
    output logic                     o_pixValid,
    output logic                     o_windowReady,
    output logic [1:0]               o_loadBank
`ifdef CONV_BANK_READBACK_EN
    ,
    input  logic                     i_rbEn,
    output logic [NB_DATA-1:0]       o_rbData
`endif
);

    // Rotation state
    phase_e    r_phase,    w_phase_nxt;
    logic [1:0] r_fillCnt, w_fillCnt_nxt;
    bank_idx_t r_base,     w_base_nxt;
    bank_idx_t r_loadBank, w_loadBank_nxt;

    // Read pipeline
    logic                     r_rdValid1;
    bank_idx_t                r_winBase1;
    logic                     r_pixValid;
    logic [N_WIN*NB_DATA-1:0] r_pix;
    logic [N_WIN*NB_DATA-1:0] w_pix_nxt;
    logic [NB_DATA-1:0]       w_rdData [N_BANKS];

    // State register
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_phase    <= PH_FILL;
            r_fillCnt  <= 2'd0;
            r_base     <= bank_idx_t'(0);
            r_loadBank <= bank_idx_t'(0);
        end else begin
            r_phase    <= w_phase_nxt;
            r_fillCnt  <= w_fillCnt_nxt;
            r_base     <= w_base_nxt;
            r_loadBank <= w_loadBank_nxt;
        end
    end

    // Next-state: the load bank index is kept registered alongside base so the
    // write path and o_loadBank never depend on combinational arithmetic.
    always_comb begin
        w_phase_nxt    = r_phase;
        w_fillCnt_nxt  = r_fillCnt;
        w_base_nxt     = r_base;
        w_loadBank_nxt = r_loadBank;
        if (i_changeBlock) begin
            case (r_phase)
                PH_FILL: begin
                    w_fillCnt_nxt  = r_fillCnt + 2'd1;
                    // Entering RUN with base=0 gives load bank 3 = fill_cnt.
                    w_loadBank_nxt = bank_idx_t'(r_fillCnt + 2'd1);
                    if (r_fillCnt == 2'd2) begin
                        w_phase_nxt = PH_RUN;
                    end
                end
                PH_RUN: begin
                    // Oldest window bank retires and becomes the load bank.
                    w_base_nxt     = bank_add(r_base, 1);
                    w_loadBank_nxt = r_base;
                end
                default: begin
                    w_phase_nxt = PH_FILL;
                end
            endcase
        end
    end

    // Bank instances with per-bank write select and read-port steering
    for (genvar g = 0; g < int'(N_BANKS); g++) begin : g_bank
        logic                  w_we;
        logic                  w_re;
        logic [NB_ADDRESS-1:0] w_rdAdd;

        assign w_we = i_valid && (r_loadBank == bank_idx_t'(g));
`ifdef CONV_BANK_READBACK_EN
        logic w_rbSel;
        assign w_rbSel = i_rbEn && (r_loadBank == bank_idx_t'(g));
        assign w_re    = i_rdEn || w_rbSel;
        assign w_rdAdd = w_rbSel ? i_writeAdd : i_readAdd;
`else
        assign w_re    = i_rdEn;
        assign w_rdAdd = i_readAdd;
`endif

        conv_bank_ram #(
            .NB_ADDRESS (NB_ADDRESS),
            .NB_DATA    (NB_DATA)
        ) u_ram (
            .i_CLK    (i_CLK),
            .i_we     (w_we),
            .i_wrAdd  (i_writeAdd),
            .i_wrData (i_data),
            .i_re     (w_re),
            .i_rdAdd  (w_rdAdd),
            .o_rdData (w_rdData[g])
        );
    end

    // Reorder mux: slot k takes bank base+k, using the base captured at request time
    always_comb begin
        w_pix_nxt = '0;
        for (int unsigned k = 0; k < N_WIN; k++) begin
            w_pix_nxt[k*NB_DATA +: NB_DATA] = w_rdData[bank_add(r_winBase1, k)];
        end
    end

    // Read pipeline registers
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_rdValid1 <= 1'b0;
            r_winBase1 <= bank_idx_t'(0);
            r_pixValid <= 1'b0;
            r_pix      <= '0;
        end else begin
            r_rdValid1 <= i_rdEn;
            if (i_rdEn) begin
                r_winBase1 <= r_base;
            end
            r_pixValid <= r_rdValid1;
            if (r_rdValid1) begin
                r_pix <= w_pix_nxt;
            end
        end
    end

`ifdef CONV_BANK_READBACK_EN
    bank_idx_t r_rbBank;

    // Remember which bank the readback targeted; its RAM output register holds the data.
    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            r_rbBank <= bank_idx_t'(0);
        end else if (i_rbEn) begin
            r_rbBank <= r_loadBank;
        end
    end

    assign o_rbData = w_rdData[r_rbBank];
`endif

    assign o_pix         = r_pix;
    assign o_pixValid    = r_pixValid;
    assign o_windowReady = (r_phase == PH_RUN);
    assign o_loadBank    = r_loadBank;

endmodule

// File: doc/conv_bank_rotator.md
# conv_bank_rotator

Column-buffer stage directly downstream of the address FSM in the 2D convolution datapath. Holds four column banks of image pixels: one is loaded from the host while the other three are read in parallel as a 3-column window for the convolution kernel. Consumes the FSM's read/write addresses and block-change strobe, and rotates bank roles on every completed block.

## Interface
- NB_ADDRESS, 10, bank address width; depth 2^NB_ADDRESS
- NB_DATA, 8, pixel width
- i_CLK  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_data  in  NB_DATA  host pixel to load
- i_valid  in  1  write strobe for i_data
- i_writeAdd  in  NB_ADDRESS  load-bank address, from FSM o_writeAdd
- i_readAdd  in  NB_ADDRESS  window-bank address, from FSM o_readAdd
- i_rdEn  in  1  window read request
- i_changeBlock  in  1  single-cycle block-complete strobe, from FSM
- o_pix  out  3*NB_DATA  window column; [NB_DATA-1:0] oldest bank, top slice newest
- o_pixValid  out  1  o_pix carries data for a request 2 cycles earlier
- o_windowReady  out  1  three banks filled; window reads meaningful
- o_loadBank  out  2  index of bank currently being loaded

## Operation
- Four banks, each 2^NB_ADDRESS x NB_DATA, synchronous read, single write port.
- State: fill_cnt (0..3), base (2-bit oldest-bank pointer).
- FILL (fill_cnt<3): load bank = fill_cnt; o_windowReady=0; each i_changeBlock increments fill_cnt.
- RUN (fill_cnt==3): load bank = base+3 mod 4; window banks base, base+1, base+2 mod 4; each i_changeBlock increments base (wraps 3->0), the oldest bank becomes the new load bank.
- Write: i_valid=1 writes i_data to load bank at i_writeAdd. Writes never target window banks.
- Read: i_rdEn=1 reads all three window banks at i_readAdd; in FILL, read still performed but o_pix content undefined.
- Simultaneous i_valid and i_changeBlock: write goes to the pre-change load bank; new role takes effect the following cycle.
- i_rdEn in the i_changeBlock cycle uses pre-change window banks; read in flight completes with those banks regardless of rotation.
- Reset mid-operation: fill_cnt=0, base=0, pipeline valids cleared; memory contents not cleared and not guaranteed.

## Timing
- Reset values: o_pix=0, o_pixValid=0, o_windowReady=0, o_loadBank=0.
- Read latency: 2 cycles (cycle 1 bank read, cycle 2 registered reorder mux into o_pix).
- o_pixValid = i_rdEn delayed 2 cycles; back-to-back reads give one output per cycle.
- o_windowReady rises the cycle after the third i_changeBlock; stays high until reset.
- o_loadBank updates the cycle after i_changeBlock.
- Write visible to a read of the same bank/address issued the cycle after the write.

## Configuration
- CONV_BANK_READBACK_EN defined: adds output o_rbData (NB_DATA) and input i_rbEn; i_rbEn=1 reads load bank at i_writeAdd, data on o_rbData 1 cycle later (host load verification). i_rbEn and i_valid same cycle: write takes priority, o_rbData undefined.
- Undefined: ports absent; load banks have no read use for that path.

## Structure
- Shared package: NB_ADDRESS/NB_DATA defaults, bank count (4), window width (3), bank-index type (2-bit).
- One sub-module: conv_bank_ram (single-port-write, sync-read RAM), instantiated four times; rotation logic and reorder mux in top level.

## Test plan
- Reset then idle -> all outputs 0, o_loadBank=0, o_windowReady=0.
- Load banks 0,1,2 with values addr, addr+0x40, addr+0x80 (NB_DATA=8, wrapped), strobe i_changeBlock after each -> o_windowReady=1, o_loadBank=3; read addr 5 -> o_pix={0x85,0x45,0x05} 2 cycles later with o_pixValid.
- In RUN, load bank 3 with 0xC0+addr, i_changeBlock -> o_loadBank=0, read addr 5 -> o_pix={0xC5,0x85,0x45}.
- Five further rotations -> base wraps, o_loadBank sequence 1,2,3,0,1; window order always oldest-to-newest.
- i_valid and i_changeBlock same cycle -> data lands in old load bank; verified by later window read.
- Reset asserted mid-read burst -> o_pixValid drops immediately, o_windowReady=0, o_loadBank=0; with CONV_BANK_READBACK_EN, write 0x3A at addr 7 then i_rbEn -> o_rbData=0x3A next cycle.
